divisor_secuencial: RTL
=======================

Name: divisor_secuencial

Overview:
- Multi-cycle unsigned restoring divider; one quotient bit per clock.
- Drives the shared ALU as its initiator. It sources the two operands and `alucontrol`, and consumes `resultado` and `carry`.
- Sits beside the ALU in the datapath. It lets the core execute DIV/MOD without a dedicated subtractor.
- Start/ready handshake on the command side; valid/accept handshake on the result side.

Parameters:
- n, 32, operand/result width; must match the ALU's n.
- CW, $clog2(n+1), iteration counter width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- inicio  in  1  start request; sampled only while listo=1.
- dividendo  in  n  dividend; captured when inicio & listo.
- divisor  in  n  divisor; captured when inicio & listo.
- listo  out  1  block idle and able to accept a command.
- valido  out  1  result valid; held until aceptado.
- aceptado  in  1  consumer takes the result this cycle.
- cociente  out  n  quotient.
- residuo  out  n  remainder.
- div_cero  out  1  divide-by-zero flag; qualified by valido.
- alu_entrada1  out  n  ALU operand 1 (partial remainder after shift).
- alu_entrada2  out  n  ALU operand 2 (latched divisor).
- alu_control  out  2  ALU op; constant 2'b01 (resta).
- alu_resultado  in  n  ALU difference.
- alu_carry  in  1  ALU subtract carry; 1 iff alu_entrada1 >= alu_entrada2 unsigned (no borrow).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - listo=1, valido=0, div_cero=0.
  - cociente=0, residuo=0, counter=0.
  - Internal R/Q/D registers cleared.
  - Reset takes priority in every state, including mid-CALC. Any in-flight operation is discarded with no valido pulse.
- States: IDLE, CALC, DONE.
- IDLE:
  - listo=1.
  - On inicio=1 with divisor != 0: latch D=divisor, Q=dividendo, R=0, counter=n; go to CALC.
  - On inicio=1 with divisor == 0: cociente = all ones, residuo = dividendo, div_cero=1; go to DONE. The ALU is not used.
- CALC (listo=0), each cycle:
  - Form the shifted remainder: {msb, Rs} = {R, Q[n-1]}, where msb is the bit shifted out of R.
  - Drive alu_entrada1 = Rs and alu_entrada2 = D.
  - Accept the subtraction if alu_carry=1 OR msb=1. The msb term covers the (n+1)-bit case: the difference modulo 2^n is exact.
  - If accepted: R <= alu_resultado. Otherwise: R <= Rs.
  - Q <= {Q[n-2:0], accept}.
  - counter <= counter - 1.
  - When counter reaches 1 this cycle, next state is DONE and cociente/residuo are loaded from the final Q/R.
- DONE:
  - valido=1, listo=0.
  - Outputs stay stable until aceptado=1, then go to IDLE the next cycle (listo=1). valido drops in that same transition.
  - inicio asserted during DONE is ignored. There is no overlap of result and new command in the same cycle.
- Latency:
  - Command accepted at edge t.
  - Normal division: valido first seen after edge t+n+1 (n CALC cycles plus the IDLE→CALC edge).
  - Divide by zero: valido after edge t+1.
- Outputs after drop of valido: cociente/residuo/div_cero hold their last values until the next command completes.
- ALU ports outside CALC: alu_entrada1/2 are still driven from registers, so there are no X values on ALU inputs. alu_control is always 2'b01.
- dividend < divisor: quotient 0, remainder = dividend. There is no early termination; always n iterations.
- Fully combinational path from alu_resultado/alu_carry into the R register within one cycle. The ALU is combinational, so there is no handshake with it.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op constants: ALU_SUMA=2'b00, ALU_RESTA=2'b01, ALU_AND=2'b10, ALU_OR=2'b11.
  - typedef enum logic [1:0] estado_div_t {IDLE, CALC, DONE}.
- No sub-module is required. The divider is a single FSM plus datapath.
- The bench instantiates the existing ALU and connects it to the alu_* ports.

Test Plan:
- n=32, dividendo=100, divisor=7, inicio 1 cycle → valido after 33 cycles. cociente=14, residuo=2, div_cero=0.
- dividendo=0xFFFFFFFF, divisor=0x80000001 → cociente=1, residuo=0x7FFFFFFE. This exercises the msb-accept path.
- dividendo=5, divisor=0 → valido on next cycle. cociente=0xFFFFFFFF, residuo=5, div_cero=1.
- dividendo=3, divisor=10; hold aceptado=0 for 5 cycles, then 1.
  - Result: cociente=0, residuo=3, stable throughout the hold.
  - listo returns 1 the cycle after aceptado.
  - inicio pulsed during the hold is ignored.
- Start 1000/3; assert rst_n=0 at CALC cycle 10 → next cycle listo=1, valido=0, cociente=0. The following command 9/4 yields 2 r 1.
- 200 random (dividendo, divisor) pairs, including 0xFFFFFFFF/1 and 0/x → cociente*divisor + residuo == dividendo and residuo < divisor for all.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcodes and the divider's state encoding.
package alu_pkg;

  localparam logic [1:0] ALU_SUMA  = 2'b00;
  localparam logic [1:0] ALU_RESTA = 2'b01;
  localparam logic [1:0] ALU_AND   = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } estado_div_t;

endpackage

// File: rtl/alu.sv
// Combinational datapath ALU shared by the core; carry on RESTA means no borrow.
module alu
  import alu_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [n-1:0] entrada1,
  input  logic [n-1:0] entrada2,
  input  logic [1:0]   alucontrol,
  output logic [n-1:0] resultado,
  output logic         carry
);

  logic [n:0] suma_ext;
  logic [n:0] resta_ext;

  // Subtraction as a + ~b + 1 so the carry-out is the unsigned a >= b flag.
  assign suma_ext  = {1'b0, entrada1} + {1'b0, entrada2};
  assign resta_ext = {1'b0, entrada1} + {1'b0, ~entrada2} + {{n{1'b0}}, 1'b1};

  always_comb begin
    resultado = '0;
    carry     = 1'b0;
    case (alucontrol)
      ALU_SUMA: begin
        resultado = suma_ext[n-1:0];
        carry     = suma_ext[n];
      end
      ALU_RESTA: begin
        resultado = resta_ext[n-1:0];
        carry     = resta_ext[n];
      end
      ALU_AND: resultado = entrada1 & entrada2;
      ALU_OR:  resultado = entrada1 | entrada2;
      default: resultado = '0;
    endcase
  end

endmodule

// File: rtl/divisor_secuencial.sv
// Unsigned restoring divider, one quotient bit per clock, borrowing the shared ALU
// for its trial subtraction.
module divisor_secuencial
  import alu_pkg::*;
#(
  parameter int n  = 32,
  parameter int CW = $clog2(n + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inicio,
  input  logic [n-1:0] dividendo,
  input  logic [n-1:0] divisor,
  output logic         listo,
  output logic         valido,
  input  logic         aceptado,
  output logic [n-1:0] cociente,
  output logic [n-1:0] residuo,
  output logic         div_cero,
  output logic [n-1:0] alu_entrada1,
  output logic [n-1:0] alu_entrada2,
  output logic [1:0]   alu_control,
  input  logic [n-1:0] alu_resultado,
  input  logic         alu_carry
);

  estado_div_t   state_q, state_d;
  logic [n-1:0]  r_q, r_d;
  logic [n-1:0]  q_q, q_d;
  logic [n-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [n-1:0]  coc_q, coc_d;
  logic [n-1:0]  res_q, res_d;
  logic          dz_q, dz_d;

  logic          msb;
  logic [n-1:0]  rs;
  logic          accept;

  // msb is the bit falling off R; when set the true shifted remainder exceeds
  // 2^n > D, so the subtraction must be taken and its mod-2^n result is exact.
  assign {msb, rs} = {r_q, q_q[n-1]};
  assign accept    = alu_carry | msb;

  assign alu_entrada1 = rs;
  assign alu_entrada2 = d_q;
  assign alu_control  = ALU_RESTA;

  assign listo    = (state_q == IDLE);
  assign valido   = (state_q == DONE);
  assign cociente = coc_q;
  assign residuo  = res_q;
  assign div_cero = dz_q;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    coc_d   = coc_q;
    res_d   = res_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (inicio) begin
          if (divisor != '0) begin
            d_d     = divisor;
            q_d     = dividendo;
            r_d     = '0;
            cnt_d   = CW'(n);
            state_d = CALC;
          end else begin
            coc_d   = '1;
            res_d   = dividendo;
            dz_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        r_d   = accept ? alu_resultado : rs;
        q_d   = {q_q[n-2:0], accept};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          coc_d   = q_d;
          res_d   = r_d;
          dz_d    = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (aceptado) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      coc_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      coc_q   <= coc_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end

endmodule
